// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(15,11) constants, bit positions and decode helpers
package hamming_pkg;

    localparam int CW_W  = 15;
    localparam int DW_W  = 11;
    localparam int CNT_W = 4;

    localparam int PAR_POS  [4]    = '{1, 2, 4, 8};
    localparam int DATA_POS [DW_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic {ST_SHIFT, ST_DECODE} rx_state_e;

    // Codeword bit p-1 carries Hamming position p.
    function automatic logic [CNT_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (cw[p-1]) s = s ^ CNT_W'(p);
        end
        return s;
    endfunction

    function automatic logic [DW_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DW_W-1:0] d;
        for (int i = 0; i < DW_W; i++) begin
            d[i] = cw[DATA_POS[i]-1];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome_correct.sv
// rtl/hamming_syndrome_correct.sv - combinational syndrome, single-bit fix and data extract
module hamming_syndrome_correct
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  cw_i,
    output logic [CNT_W-1:0] syndrome_o,
    output logic [DW_W-1:0]  data_o
);

    logic [CW_W-1:0] fixed_cw;

    always_comb begin
        syndrome_o = calc_syndrome(cw_i);
        fixed_cw   = cw_i;
        if (syndrome_o != '0) begin
            fixed_cw[syndrome_o - 1'b1] = ~cw_i[syndrome_o - 1'b1];
        end
        data_o = extract_data(fixed_cw);
    end

endmodule

// File: rtl/hamming_serial_rx_decoder.sv
// rtl/hamming_serial_rx_decoder.sv - serial Hamming(15,11) receiver; HAMMING_RX_STATS_EN adds frame/correction counters
module hamming_serial_rx_decoder
    import hamming_pkg::*;
(
    input  logic              CLK,
    input  logic              REST,
    input  logic              DEVICE_EN,
    input  logic              BIT_EN,
    input  logic              SERIAL_IN,
    output logic [DW_W-1:0]   DATA_OUT,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic              CORRECTED,
    output logic [CNT_W-1:0]  ERR_POS,
    output logic              OVERRUN
`ifdef HAMMING_RX_STATS_EN
    ,
    output logic [15:0]       FRAME_CNT,
    output logic [15:0]       CORR_CNT
`endif
);

    rx_state_e        state_q, state_d;
    logic [CW_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW_W-1:0]  data_q, data_d;
    logic             valid_q, valid_d;
    logic             corr_q, corr_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             ovr_q, ovr_d;

    logic [CNT_W-1:0] syndrome;
    logic [DW_W-1:0]  fixed_data;
    logic             strobe;
    logic             accept;

    hamming_syndrome_correct u_dec (
        .cw_i       (shreg_q),
        .syndrome_o (syndrome),
        .data_o     (fixed_data)
    );

    assign strobe = DEVICE_EN & BIT_EN;
    assign accept = valid_q & DATA_READY;

    always_comb begin
        state_d = ST_SHIFT;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        corr_d  = corr_q;
        pos_d   = pos_q;
        ovr_d   = 1'b0;

        if (strobe) begin
            shreg_d[cnt_q] = SERIAL_IN;
            if (cnt_q == CNT_W'(CW_W - 1)) begin
                cnt_d   = '0;
                state_d = ST_DECODE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (accept) valid_d = 1'b0;

        // The shift register still holds the full frame here; a new first bit only lands on this edge.
        if (state_q == ST_DECODE) begin
            if (!valid_q || DATA_READY) begin
                data_d  = fixed_data;
                corr_d  = (syndrome != '0);
                pos_d   = syndrome;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            state_q <= ST_SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            corr_q  <= 1'b0;
            pos_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            corr_q  <= corr_d;
            pos_q   <= pos_d;
            ovr_q   <= ovr_d;
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign CORRECTED  = corr_q;
    assign ERR_POS    = pos_q;
    assign OVERRUN    = ovr_q;

`ifdef HAMMING_RX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] corr_cnt_q, corr_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        corr_cnt_d  = corr_cnt_q;
        if (state_q == ST_DECODE) begin
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            if (syndrome != '0 && corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            frame_cnt_q <= '0;
            corr_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            corr_cnt_q  <= corr_cnt_d;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
    assign CORR_CNT  = corr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_serial_rx_decoder.sv
// tb/tb_hamming_serial_rx_decoder.sv - directed vector bench for hamming_serial_rx_decoder
module tb_hamming_serial_rx_decoder;

    logic        CLK = 1'b0;
    logic        REST = 1'b0;
    logic        DEVICE_EN = 1'b0;
    logic        BIT_EN = 1'b0;
    logic        SERIAL_IN = 1'b0;
    logic [10:0] DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY = 1'b1;
    logic        CORRECTED;
    logic [3:0]  ERR_POS;
    logic        OVERRUN;
`ifdef HAMMING_RX_STATS_EN
    logic [15:0] FRAME_CNT;
    logic [15:0] CORR_CNT;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    hamming_serial_rx_decoder dut (
        .CLK        (CLK),
        .REST       (REST),
        .DEVICE_EN  (DEVICE_EN),
        .BIT_EN     (BIT_EN),
        .SERIAL_IN  (SERIAL_IN),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .CORRECTED  (CORRECTED),
        .ERR_POS    (ERR_POS),
        .OVERRUN    (OVERRUN)
`ifdef HAMMING_RX_STATS_EN
        ,
        .FRAME_CNT  (FRAME_CNT),
        .CORR_CNT   (CORR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [14:0] cw;
        logic [10:0] exp_data;
        logic        exp_corr;
        logic [3:0]  exp_pos;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic en);
        DEVICE_EN = en;
        BIT_EN    = 1'b1;
        SERIAL_IN = b;
        tick();
        BIT_EN    = 1'b0;
        DEVICE_EN = 1'b1;
    endtask

    task automatic send_bits(input logic [14:0] cw, input int first, input int last);
        for (int p = first; p <= last; p++) send_bit(cw[p-1], 1'b1);
    endtask

    initial begin
        vecs[0] = '{"zero",        15'h0000, 11'h000, 1'b0, 4'd0};
        vecs[1] = '{"ones",        15'h7FFF, 11'h7FF, 1'b0, 4'd0};
        vecs[2] = '{"ones_err5",   15'h7FEF, 11'h7FF, 1'b1, 4'd5};
        vecs[3] = '{"zero_err4",   15'h0008, 11'h000, 1'b1, 4'd4};
        vecs[4] = '{"d0_clean",    15'h0007, 11'h001, 1'b0, 4'd0};
        vecs[5] = '{"d0_err3",     15'h0003, 11'h001, 1'b1, 4'd3};
        vecs[6] = '{"zero_err15",  15'h4000, 11'h000, 1'b1, 4'd15};
        vecs[7] = '{"d10_clean",   15'h408B, 11'h400, 1'b0, 4'd0};
        vecs[8] = '{"double_err",  15'h0003, 11'h001, 1'b1, 4'd3};
        vecs[8].cw = 15'h0003 ^ 15'h0007; // positions 3 only -> use 1,2 flip of zero frame below
        vecs[8].cw = 15'h0003 & 15'h0003;
        vecs[8].name = "double_err";
        vecs[8].cw = {13'h0, 2'b11};

        #12;
        check("reset_data",  {5'h0, DATA_OUT}, 16'h0000);
        check("reset_valid", {15'h0, DATA_VALID}, 16'h0000);
        check("reset_corr",  {15'h0, CORRECTED}, 16'h0000);
        check("reset_pos",   {12'h0, ERR_POS}, 16'h0000);
        check("reset_ovr",   {15'h0, OVERRUN}, 16'h0000);
        REST = 1'b1;
        DEVICE_EN = 1'b1;
        tick();

        DATA_READY = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_bits(vecs[i].cw, 1, 15);
            check({vecs[i].name, "_early_valid"}, {15'h0, DATA_VALID}, 16'h0000);
            tick();
            check({vecs[i].name, "_valid"}, {15'h0, DATA_VALID}, 16'h0001);
            check({vecs[i].name, "_data"},  {5'h0, DATA_OUT}, {5'h0, vecs[i].exp_data});
            check({vecs[i].name, "_corr"},  {15'h0, CORRECTED}, {15'h0, vecs[i].exp_corr});
            check({vecs[i].name, "_pos"},   {12'h0, ERR_POS}, {12'h0, vecs[i].exp_pos});
            tick();
            check({vecs[i].name, "_valid_drop"}, {15'h0, DATA_VALID}, 16'h0000);
        end

        // Backpressure: second completion must be dropped with a single OVERRUN pulse.
        DATA_READY = 1'b0;
        send_bits(15'h7FFF, 1, 15);
        tick();
        check("bp_first_valid", {15'h0, DATA_VALID}, 16'h0001);
        send_bits(15'h0000, 1, 15);
        check("bp_ovr_before", {15'h0, OVERRUN}, 16'h0000);
        tick();
        check("bp_ovr_pulse", {15'h0, OVERRUN}, 16'h0001);
        check("bp_hold_data", {5'h0, DATA_OUT}, 16'h07FF);
        tick();
        check("bp_ovr_clear", {15'h0, OVERRUN}, 16'h0000);
        check("bp_still_valid", {15'h0, DATA_VALID}, 16'h0001);
        check("bp_still_data", {5'h0, DATA_OUT}, 16'h07FF);
        DATA_READY = 1'b1;
        tick();
        check("bp_accept_drop", {15'h0, DATA_VALID}, 16'h0000);

        // Gating: DEVICE_EN low with strobes for 20 cycles after bit 7.
        send_bits(15'h408B, 1, 7);
        for (int k = 0; k < 20; k++) send_bit(k[0], 1'b0);
        check("gate_no_valid", {15'h0, DATA_VALID}, 16'h0000);
        send_bits(15'h408B, 8, 15);
        tick();
        check("gate_valid", {15'h0, DATA_VALID}, 16'h0001);
        check("gate_data", {5'h0, DATA_OUT}, 16'h0400);
        check("gate_corr", {15'h0, CORRECTED}, 16'h0000);
        tick();

        // Reset mid-frame with a held word present.
        DATA_READY = 1'b0;
        send_bits(15'h7FEF, 1, 15);
        tick();
        check("rst_pre_valid", {15'h0, DATA_VALID}, 16'h0001);
        send_bits(15'h7FFF, 1, 9);
        #2;
        REST = 1'b0;
        #1;
        check("rst_async_valid", {15'h0, DATA_VALID}, 16'h0000);
        check("rst_async_data", {5'h0, DATA_OUT}, 16'h0000);
        check("rst_async_corr", {15'h0, CORRECTED}, 16'h0000);
        check("rst_async_pos", {12'h0, ERR_POS}, 16'h0000);
        tick();
        REST = 1'b1;
        DATA_READY = 1'b1;
        tick();
        send_bits(15'h0003, 1, 15);
        tick();
        check("rst_fresh_valid", {15'h0, DATA_VALID}, 16'h0001);
        check("rst_fresh_data", {5'h0, DATA_OUT}, 16'h0001);
        check("rst_fresh_pos", {12'h0, ERR_POS}, 16'h0003);
`ifdef HAMMING_RX_STATS_EN
        check("stats_frames", FRAME_CNT, 16'd1);
        check("stats_corr", CORR_CNT, 16'd1);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
